// File: rtl/gray_counter8.sv
// Free-running WIDTH-bit Gray-code counter with a registered, glitch-free output.
// Optional macro GRAY_COUNTER8_BIN_OUT_EN adds a cycle-aligned binary output bin_count.
module gray_counter8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef GRAY_COUNTER8_BIN_OUT_EN
  output logic [WIDTH-1:0] bin_count,
`endif
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_bin_q;
  logic [WIDTH-1:0] r_count_q;
  logic [WIDTH-1:0] w_bin_nxt;

  assign w_bin_nxt = r_bin_q + WIDTH'(1);

  // Gray value is computed from the next binary value so the flop holds Gray(bin_q).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin_q   <= '0;
      r_count_q <= '0;
    end else begin
      r_bin_q   <= w_bin_nxt;
      r_count_q <= w_bin_nxt ^ (w_bin_nxt >> 1);
    end
  end

  assign count = r_count_q;

`ifdef GRAY_COUNTER8_BIN_OUT_EN
  assign bin_count = r_bin_q;
`endif

endmodule

// File: tb/tb_gray_counter8.sv
// Self-checking bench for gray_counter8: directed scenarios plus randomized resets
// checked against a counting model; define GRAY_COUNTER8_BIN_OUT_EN to cover bin_count.
module tb_gray_counter8;

  logic       clk;
  logic       rst;
  logic [7:0] count;
`ifdef GRAY_COUNTER8_BIN_OUT_EN
  logic [7:0] bin_count;
`endif

  int checks;
  int failures;

  gray_counter8 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef GRAY_COUNTER8_BIN_OUT_EN
    .bin_count(bin_count),
`endif
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: Gray code of n is n XOR (n/2), from the definition of reflected binary.
  function automatic logic [7:0] gray_of(input int n);
    int m;
    m = n % 256;
    return 8'(m ^ (m / 2));
  endfunction

  // Decode by prefix-XOR from the MSB down.
  function automatic int gray_decode(input logic [7:0] g);
    int b;
    logic acc;
    b = 0;
    acc = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      acc = acc ^ g[i];
      if (acc) b = b + (1 << i);
    end
    return b;
  endfunction

  // Advance one edge, then sample away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (count !== 8'h00) begin
        failures++;
        $display("FAIL reset_hold edge=%0d count=%h expected=00", i, count);
      end
`ifdef GRAY_COUNTER8_BIN_OUT_EN
      checks++;
      if (bin_count !== 8'h00) begin
        failures++;
        $display("FAIL reset_bin edge=%0d bin_count=%h expected=00", i, bin_count);
      end
`endif
    end
  endtask

  task automatic test_sequence();
    logic [7:0] exp_seq [8];
    exp_seq = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C};
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (count !== exp_seq[i]) begin
        failures++;
        $display("FAIL sequence step=%0d count=%h expected=%h", i, count, exp_seq[i]);
      end
    end
  endtask

  task automatic test_gray_property();
    logic [7:0] prev;
    do_reset();
    prev = count;
    for (int i = 1; i <= 300; i++) begin
      step();
      checks++;
      if ($countones(prev ^ count) != 1) begin
        failures++;
        $display("FAIL gray_step cycle=%0d prev=%h count=%h expected_bits_changed=1", i, prev, count);
      end
      if (i == 255 || i == 256) begin
        checks++;
        if (count !== gray_of(i)) begin
          failures++;
          $display("FAIL wrap cycle=%0d count=%h expected=%h", i, count, gray_of(i));
        end
      end
      prev = count;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 100; i++) step();
    checks++;
    if (count !== 8'h56) begin
      failures++;
      $display("FAIL mid_count count=%h expected=56", count);
    end
    rst = 1'b1;
    step();
    checks++;
    if (count !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset count=%h expected=00", count);
    end
    rst = 1'b0;
    step();
    checks++;
    if (count !== 8'h01) begin
      failures++;
      $display("FAIL mid_resume count=%h expected=01", count);
    end
  endtask

  task automatic test_sweep();
    int seen [256];
    int prev_b;
    int cur_b;
    for (int i = 0; i < 256; i++) seen[i] = 0;
    do_reset();
    prev_b = gray_decode(count);
    seen[count]++;
    for (int i = 1; i < 256; i++) begin
      step();
      cur_b = gray_decode(count);
      checks++;
      if (cur_b != (prev_b + 1) % 256) begin
        failures++;
        $display("FAIL sweep_monotonic cycle=%0d decoded=%0d expected=%0d", i, cur_b, (prev_b + 1) % 256);
      end
      if (!$isunknown(count)) seen[count]++;
      prev_b = cur_b;
    end
    for (int v = 0; v < 256; v++) begin
      checks++;
      if (seen[v] != 1) begin
        failures++;
        $display("FAIL sweep_coverage value=%h occurrences=%0d expected=1", v[7:0], seen[v]);
      end
    end
  endtask

  // Random reset pulses against a model that just counts edges since the last reset.
  task automatic test_random();
    int n;
    do_reset();
    n = 0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      step();
      n = rst ? 0 : (n + 1) % 256;
      checks++;
      if (count !== gray_of(n)) begin
        failures++;
        $display("FAIL random cycle=%0d rst=%0b count=%h expected=%h", i, rst, count, gray_of(n));
      end
`ifdef GRAY_COUNTER8_BIN_OUT_EN
      checks++;
      if (bin_count !== 8'(n)) begin
        failures++;
        $display("FAIL random_bin cycle=%0d bin_count=%h expected=%h", i, bin_count, 8'(n));
      end
`endif
    end
    rst = 1'b0;
  endtask

`ifdef GRAY_COUNTER8_BIN_OUT_EN
  task automatic test_bin_out();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i > 0) step();
      checks++;
      if (bin_count !== 8'(i)) begin
        failures++;
        $display("FAIL bin_out cycle=%0d bin_count=%h expected=%h", i, bin_count, 8'(i));
      end
      checks++;
      if (count !== (bin_count ^ (bin_count >> 1))) begin
        failures++;
        $display("FAIL bin_gray_align cycle=%0d count=%h bin_count=%h", i, count, bin_count);
      end
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_sequence();
    test_gray_property();
    test_mid_reset();
    test_sweep();
    test_random();
`ifdef GRAY_COUNTER8_BIN_OUT_EN
    test_bin_out();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
